// File: rtl/uart_cmd_pkg.sv
// Shared constants, parser state type and byte-classification helpers for the
// UART command decoder.
package uart_cmd_pkg;

    localparam int unsigned BTN_W = 5;
    localparam int unsigned RPT_W = 4;
    localparam int unsigned CNT_W = 7;

    localparam logic [7:0] ASC_C    = 8'h63;
    localparam logic [7:0] ASC_U    = 8'h75;
    localparam logic [7:0] ASC_D    = 8'h64;
    localparam logic [7:0] ASC_L    = 8'h6C;
    localparam logic [7:0] ASC_R    = 8'h72;
    localparam logic [7:0] ASC_W    = 8'h77;
    localparam logic [7:0] ASC_S    = 8'h73;
    localparam logic [7:0] ASC_T    = 8'h74;
    localparam logic [7:0] ASC_H    = 8'h68;
    localparam logic [7:0] ASC_X    = 8'h78;
    localparam logic [7:0] ASC_0    = 8'h30;
    localparam logic [7:0] ASC_9    = 8'h39;
    localparam logic [7:0] ASC_HASH = 8'h23;
    localparam logic [7:0] ASC_ESC  = 8'h1B;
    localparam logic [7:0] ASC_CR   = 8'h0D;
    localparam logic [7:0] ASC_LF   = 8'h0A;

    localparam int unsigned BTN_C = 4;
    localparam int unsigned BTN_U = 3;
    localparam int unsigned BTN_D = 2;
    localparam int unsigned BTN_L = 1;
    localparam int unsigned BTN_R = 0;

    localparam int unsigned RPT_WATCH = 3;
    localparam int unsigned RPT_SR04  = 2;
    localparam int unsigned RPT_TEMP  = 1;
    localparam int unsigned RPT_HUMID = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREFIX,
        ST_DIGIT,
        ST_REPEAT
    } state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASC_0) && (b <= ASC_9);
    endfunction

    function automatic logic is_btn(input logic [7:0] b);
        return (b == ASC_C) || (b == ASC_U) || (b == ASC_D) ||
               (b == ASC_L) || (b == ASC_R);
    endfunction

    function automatic logic [2:0] btn_idx(input logic [7:0] b);
        logic [2:0] idx;
        case (b)
            ASC_C:   idx = 3'(BTN_C);
            ASC_U:   idx = 3'(BTN_U);
            ASC_D:   idx = 3'(BTN_D);
            ASC_L:   idx = 3'(BTN_L);
            default: idx = 3'(BTN_R);
        endcase
        return idx;
    endfunction

    // Upper-case letters map onto lower case only when folding is enabled.
    function automatic logic [7:0] fold_case(input logic [7:0] b, input logic en);
        logic [7:0] r;
        r = b;
        if (en && (b >= 8'h41) && (b <= 8'h5A)) r = b | 8'h20;
        return r;
    endfunction

endpackage

// File: rtl/uart_cmd_repeater.sv
// Paced button pulse train: first pulse registered on the start edge, then one
// pulse every PULSE_GAP+1 cycles until count pulses have been emitted.
module uart_cmd_repeater
    import uart_cmd_pkg::*;
#(
    parameter int unsigned PULSE_GAP = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       btn_idx,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    output logic [BTN_W-1:0] pulse,
    output logic             done
);

    localparam int unsigned GAP_W = $clog2(PULSE_GAP + 1);

    logic             active;
    logic [2:0]       idx_q;
    logic [CNT_W-1:0] remaining;
    logic [GAP_W-1:0] gap;

    // done is high alongside the last pulse; the following edge retires the train.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            active    <= 1'b0;
            idx_q     <= 3'd0;
            remaining <= '0;
            gap       <= '0;
            pulse     <= '0;
            done      <= 1'b0;
        end else if (start) begin
            active    <= 1'b1;
            idx_q     <= btn_idx;
            remaining <= count - CNT_W'(1);
            gap       <= GAP_W'(PULSE_GAP);
            pulse     <= BTN_W'(1) << btn_idx;
            done      <= (count == CNT_W'(1));
        end else if (active) begin
            if (done) begin
                active <= 1'b0;
                pulse  <= '0;
                done   <= 1'b0;
            end else if (gap == GAP_W'(0)) begin
                pulse     <= BTN_W'(1) << idx_q;
                remaining <= remaining - CNT_W'(1);
                gap       <= GAP_W'(PULSE_GAP);
                done      <= (remaining == CNT_W'(1));
            end else begin
                pulse <= '0;
                gap   <= gap - GAP_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder: single-letter commands become one-cycle pulses and a
// "#<n><btn>" prefix launches a paced repeat train; every byte is echoed.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned NUM_SW      = 4,
    parameter int unsigned PULSE_GAP   = 3,
    parameter int unsigned CMD_TIMEOUT = 1000,
    parameter int unsigned CASE_FOLD   = 1
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [7:0]        iRxData,
    input  logic              iRxValid,
    output logic [BTN_W-1:0]  oBtn,
    output logic [NUM_SW-1:0] oTglSw,
    output logic              oClrSwTgl,
    output logic [RPT_W-1:0]  oReqRpt,
    output logic [7:0]        oLoopData,
    output logic              oLoopValid,
    output logic              oBusy,
    output logic              oErr
);

    localparam int unsigned TMR_W = $clog2(CMD_TIMEOUT + 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   count, count_next;
    logic               two_dig, two_dig_next;
    logic [TMR_W-1:0]   timer, timer_next;

    logic [7:0]         cmd;
    logic [3:0]         digit;
    logic               rx_digit, rx_btn, esc, in_prefix, timeout_c;

    logic               rep_start, rep_done;
    logic [2:0]         rep_idx;
    logic [CNT_W-1:0]   rep_count;

    logic [NUM_SW-1:0]  tgl_next;
    logic               clr_next, err_next;
    logic [RPT_W-1:0]   rpt_next;

    assign cmd       = fold_case(iRxData, CASE_FOLD != 0);
    assign digit     = 4'(iRxData - ASC_0);
    assign rx_digit  = iRxValid && is_digit(iRxData);
    assign rx_btn    = iRxValid && is_btn(cmd);
    assign esc       = iRxValid && (iRxData == ASC_ESC);
    assign in_prefix = (state == ST_PREFIX) || (state == ST_DIGIT);
    // A byte on the expiry edge takes precedence over the timeout.
    assign timeout_c = in_prefix && !iRxValid && (timer == TMR_W'(CMD_TIMEOUT - 1));

    always_ff @(posedge iClk) begin
        if (iRst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (esc) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (iRxValid && (iRxData == ASC_HASH)) state_next = ST_PREFIX;
                ST_PREFIX: begin
                    if (rx_digit)                    state_next = ST_DIGIT;
                    else if (iRxValid || timeout_c)  state_next = ST_IDLE;
                end
                ST_DIGIT: begin
                    if (rx_digit && !two_dig)                  state_next = ST_DIGIT;
                    else if (rx_btn && (count != CNT_W'(0)))   state_next = ST_REPEAT;
                    else if (iRxValid || timeout_c)            state_next = ST_IDLE;
                end
                ST_REPEAT: if (rep_done) state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // Next values for the registered outputs, count, digit flag and timer.
    always_comb begin
        count_next   = count;
        two_dig_next = two_dig;
        timer_next   = '0;
        rep_start    = 1'b0;
        rep_idx      = btn_idx(cmd);
        rep_count    = CNT_W'(1);
        tgl_next     = '0;
        clr_next     = 1'b0;
        rpt_next     = '0;
        err_next     = 1'b0;

        if (in_prefix && !iRxValid) timer_next = timer + TMR_W'(1);

        if (!esc) begin
            case (state)
                ST_IDLE: begin
                    rep_start = rx_btn;
                    if (rx_digit && (32'(digit) < NUM_SW)) tgl_next = NUM_SW'(1) << digit;
                    clr_next            = iRxValid && (cmd == ASC_X);
                    rpt_next[RPT_WATCH] = iRxValid && (cmd == ASC_W);
                    rpt_next[RPT_SR04]  = iRxValid && (cmd == ASC_S);
                    rpt_next[RPT_TEMP]  = iRxValid && (cmd == ASC_T);
                    rpt_next[RPT_HUMID] = iRxValid && (cmd == ASC_H);
                    if (iRxValid && (iRxData == ASC_HASH)) begin
                        count_next   = '0;
                        two_dig_next = 1'b0;
                    end
                end
                ST_PREFIX: begin
                    if (rx_digit) begin
                        count_next   = CNT_W'(digit);
                        two_dig_next = 1'b0;
                    end else if (iRxValid || timeout_c) begin
                        err_next = 1'b1;
                    end
                end
                ST_DIGIT: begin
                    if (rx_digit) begin
                        if (two_dig) begin
                            err_next = 1'b1;
                        end else begin
                            count_next   = count * CNT_W'(10) + CNT_W'(digit);
                            two_dig_next = 1'b1;
                        end
                    end else if (rx_btn) begin
                        if (count == CNT_W'(0)) begin
                            err_next = 1'b1;
                        end else begin
                            rep_start = 1'b1;
                            rep_count = count;
                        end
                    end else if (iRxValid || timeout_c) begin
                        err_next = 1'b1;
                    end
                end
                ST_REPEAT: err_next = iRxValid;
                default:   err_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            count      <= '0;
            two_dig    <= 1'b0;
            timer      <= '0;
            oTglSw     <= '0;
            oClrSwTgl  <= 1'b0;
            oReqRpt    <= '0;
            oLoopData  <= 8'h00;
            oLoopValid <= 1'b0;
            oBusy      <= 1'b0;
            oErr       <= 1'b0;
        end else begin
            count      <= count_next;
            two_dig    <= two_dig_next;
            timer      <= timer_next;
            oTglSw     <= tgl_next;
            oClrSwTgl  <= clr_next;
            oReqRpt    <= rpt_next;
            oLoopData  <= iRxValid ? iRxData : 8'h00;
            oLoopValid <= iRxValid;
            oBusy      <= (state_next != ST_IDLE);
            oErr       <= err_next;
        end
    end

    uart_cmd_repeater #(
        .PULSE_GAP (PULSE_GAP)
    ) u_repeater (
        .clk     (iClk),
        .rst     (iRst),
        .start   (rep_start),
        .btn_idx (rep_idx),
        .count   (rep_count),
        .abort   (esc),
        .pulse   (oBtn),
        .done    (rep_done)
    );

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: one folding and one non-folding instance
// share the same byte stream.
module tb_uart_cmd_decoder;

    localparam int unsigned TO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;

    logic [4:0] btn_a, btn_b;
    logic [3:0] tgl_a, tgl_b, rpt_a, rpt_b;
    logic       clr_a, clr_b, lv_a, lv_b, busy_a, busy_b, err_a, err_b;
    logic [7:0] ld_a, ld_b;
    logic [15:0] obs;

    int checks = 0;
    int errors = 0;

    logic [7:0]  sb [16];
    logic [15:0] se [16];

    uart_cmd_decoder #(.NUM_SW(4), .PULSE_GAP(3), .CMD_TIMEOUT(TO), .CASE_FOLD(1)) dut_a (
        .iClk(clk), .iRst(rst), .iRxData(rx_data), .iRxValid(rx_valid),
        .oBtn(btn_a), .oTglSw(tgl_a), .oClrSwTgl(clr_a), .oReqRpt(rpt_a),
        .oLoopData(ld_a), .oLoopValid(lv_a), .oBusy(busy_a), .oErr(err_a));

    uart_cmd_decoder #(.NUM_SW(4), .PULSE_GAP(3), .CMD_TIMEOUT(TO), .CASE_FOLD(0)) dut_b (
        .iClk(clk), .iRst(rst), .iRxData(rx_data), .iRxValid(rx_valid),
        .oBtn(btn_b), .oTglSw(tgl_b), .oClrSwTgl(clr_b), .oReqRpt(rpt_b),
        .oLoopData(ld_b), .oLoopValid(lv_b), .oBusy(busy_b), .oErr(err_b));

    always #5 clk = ~clk;

    assign obs = {btn_a, tgl_a, clr_a, rpt_a, busy_a, err_a};

    function automatic logic [15:0] mk(input logic [4:0] b, input logic [3:0] t, input logic c,
                                       input logic [3:0] r, input logic bu, input logic e);
        return {b, t, c, r, bu, e};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the byte is sampled on the next posedge and the
    // task returns at the following negedge, where that edge's outputs are visible.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [4:0] seen;
        logic       flag;
        int         np;

        sb = '{8'h63, 8'h75, 8'h64, 8'h6C, 8'h72, 8'h77, 8'h73, 8'h74,
               8'h68, 8'h78, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D};
        se = '{mk(5'b10000, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0),
               mk(5'b01000, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0),
               mk(5'b00100, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0),
               mk(5'b00010, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0),
               mk(5'b00001, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0),
               mk(5'b00000, 4'h0, 1'b0, 4'b1000, 1'b0, 1'b0),
               mk(5'b00000, 4'h0, 1'b0, 4'b0100, 1'b0, 1'b0),
               mk(5'b00000, 4'h0, 1'b0, 4'b0010, 1'b0, 1'b0),
               mk(5'b00000, 4'h0, 1'b0, 4'b0001, 1'b0, 1'b0),
               mk(5'b00000, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0),
               mk(5'b00000, 4'b0001, 1'b0, 4'h0, 1'b0, 1'b0),
               mk(5'b00000, 4'b0010, 1'b0, 4'h0, 1'b0, 1'b0),
               mk(5'b00000, 4'b0100, 1'b0, 4'h0, 1'b0, 1'b0),
               mk(5'b00000, 4'b1000, 1'b0, 4'h0, 1'b0, 1'b0),
               16'h0000,
               16'h0000};

        tick(2);
        chk("reset_out", obs, 16'h0000);
        chk("reset_loop", 16'({lv_a, ld_a}), 16'h0000);
        rst = 1'b0;
        tick(1);

        for (int i = 0; i < 16; i++) begin
            send(sb[i]);
            chk($sformatf("single_%h", sb[i]), obs, se[i]);
            chk($sformatf("loop_%h", sb[i]), 16'({lv_a, ld_a}), 16'({1'b1, sb[i]}));
            tick(1);
            chk($sformatf("clear_%h", sb[i]), obs, 16'h0000);
        end

        send(8'h43);
        chk("fold_btn", obs, mk(5'b10000, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0));
        chk("fold_loop", 16'({lv_a, ld_a}), 16'h0143);
        chk("nofold_btn", 16'(btn_b), 16'h0000);
        tick(1);

        // "#12u": 12 pulses on bit 3, 4 cycles apart
        send(8'h23);
        chk("hash_busy", obs, mk(5'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0));
        send(8'h31);
        send(8'h32);
        send(8'h75);
        chk("rpt_p1", obs, mk(5'b01000, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0));
        for (int k = 2; k <= 12; k++) begin
            tick(3);
            chk($sformatf("rpt_gap%0d", k), obs, mk(5'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0));
            tick(1);
            chk($sformatf("rpt_p%0d", k), obs, mk(5'b01000, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0));
        end
        tick(1);
        chk("rpt_end", obs, 16'h0000);

        // "#5r" aborted by ESC on the edge that would launch pulse 3
        send(8'h23);
        send(8'h35);
        send(8'h72);
        chk("esc_p1", obs, mk(5'b00001, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0));
        tick(4);
        chk("esc_p2", obs, mk(5'b00001, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0));
        tick(3);
        send(8'h1B);
        chk("esc_nopulse", obs, 16'h0000);
        seen = '0;
        flag = 1'b0;
        repeat (20) begin
            tick(1);
            seen |= btn_a;
            flag |= err_a | busy_a;
        end
        chk("esc_quiet", 16'({seen, flag}), 16'h0000);

        // "#5r" interrupted by reset
        send(8'h23);
        send(8'h35);
        send(8'h72);
        chk("rst_p1", obs, mk(5'b00001, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0));
        tick(1);
        rst = 1'b1;
        tick(1);
        chk("rst_mid_out", obs, 16'h0000);
        chk("rst_mid_loop", 16'({lv_a, ld_a}), 16'h0000);
        rst = 1'b0;
        seen = '0;
        flag = 1'b0;
        repeat (20) begin
            tick(1);
            seen |= btn_a;
            flag |= busy_a;
        end
        chk("rst_quiet", 16'({seen, flag}), 16'h0000);

        // Parse errors
        send(8'h23);
        send(8'h30);
        send(8'h63);
        chk("err_cnt0", obs, mk(5'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1));
        tick(1);
        chk("err_cnt0_clr", obs, 16'h0000);
        send(8'h23);
        send(8'h31);
        send(8'h32);
        chk("two_digit_busy", obs, mk(5'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0));
        send(8'h33);
        chk("err_3dig", obs, mk(5'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1));
        tick(1);
        send(8'h23);
        send(8'h71);
        chk("err_prefix", obs, mk(5'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1));
        tick(1);

        // Timeout after "#4"
        send(8'h23);
        send(8'h34);
        tick(TO - 1);
        chk("to_before", obs, mk(5'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0));
        tick(1);
        chk("to_fire", obs, mk(5'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1));
        tick(1);
        chk("to_clear", obs, 16'h0000);

        // Byte on the exact expiry edge wins
        send(8'h23);
        send(8'h34);
        tick(TO - 1);
        send(8'h72);
        chk("to_race", obs, mk(5'b00001, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0));
        np = 1;
        flag = 1'b0;
        repeat (16) begin
            tick(1);
            np += int'(btn_a[0]);
            flag |= err_a;
        end
        chk("race_count", 16'(np), 16'd4);
        chk("race_noerr", 16'(flag), 16'h0000);
        chk("race_idle", obs, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
